// File: rtl/idli_sqi_arb_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_sqi_arb_m
// Brief    : Word-granular arbiter sharing the SQI port between fetch and LSU.
// Revision : 1.0 - initial release
// ============================================================================
module idli_sqi_arb_m (
  input  logic        i_arb_gck,
  input  logic        i_arb_rst_n,
  input  logic [1:0]  i_arb_ctr,
  input  logic        i_arb_ctr_last_cycle,
  input  logic        i_arb_fetch_req,
  input  logic [15:0] i_arb_fetch_addr,
  input  logic        i_arb_fetch_flush,
  input  logic        i_arb_lsu_req,
  input  logic        i_arb_lsu_wr,
  input  logic [15:0] i_arb_lsu_addr,
  input  logic [15:0] i_arb_lsu_wr_data,
  output logic        o_arb_redirect,
  output logic        o_arb_sqi_rd,
  output logic [3:0]  o_arb_sqi_wr_data,
  output logic        o_arb_sqi_wr_data_vld,
  output logic        o_arb_fetch_vld,
  output logic        o_arb_lsu_rd_vld,
  output logic        o_arb_lsu_done,
  output logic        o_arb_busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDR   = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_LSU   = 1'b1;

  logic [1:0]  r_state;
  logic        r_owner;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_wr;

  logic [1:0]  w_next_state;
  logic        w_grant_lsu;
  logic        w_grant_fetch;

  // Next-state decision; only consumed on the word-boundary edge.
  always_comb begin
    w_next_state  = r_state;
    w_grant_lsu   = 1'b0;
    w_grant_fetch = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_arb_lsu_req)        w_grant_lsu   = 1'b1;
        else if (i_arb_fetch_req) w_grant_fetch = 1'b1;
      end
      ST_ADDR: w_next_state = ST_DATA;
      ST_DATA: begin
        if (r_owner == OWN_LSU) begin
          // LSU holds the port for exactly one word, then fetch gets a turn.
          if (i_arb_fetch_req) w_grant_fetch = 1'b1;
          else                 w_next_state  = ST_IDLE;
        end else begin
          if (i_arb_lsu_req)          w_grant_lsu   = 1'b1;
          else if (i_arb_fetch_flush) w_grant_fetch = 1'b1;
          else if (!i_arb_fetch_req)  w_next_state  = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_grant_lsu || w_grant_fetch) w_next_state = ST_ADDR;
  end

  always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
    if (!i_arb_rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_FETCH;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_wr    <= 1'b0;
    end else if (i_arb_ctr_last_cycle) begin
      r_state <= w_next_state;
      if (w_grant_lsu) begin
        r_owner <= OWN_LSU;
        r_addr  <= i_arb_lsu_addr;
        r_data  <= i_arb_lsu_wr_data;
        r_wr    <= i_arb_lsu_wr;
      end else if (w_grant_fetch) begin
        r_owner <= OWN_FETCH;
        r_addr  <= i_arb_fetch_addr;
      end
    end
  end

  logic w_in_addr;
  logic w_in_data;
  logic w_lsu_data;
  logic w_lsu_store;

  assign w_in_addr   = (r_state == ST_ADDR);
  assign w_in_data   = (r_state == ST_DATA);
  assign w_lsu_data  = w_in_data && (r_owner == OWN_LSU);
  assign w_lsu_store = w_lsu_data && r_wr;

  assign o_arb_redirect        = w_in_addr;
  assign o_arb_sqi_rd          = !(w_in_addr || w_lsu_store);
  assign o_arb_sqi_wr_data     = w_in_addr   ? r_addr[{i_arb_ctr, 2'b00} +: 4] :
                                 w_lsu_store ? r_data[{i_arb_ctr, 2'b00} +: 4] :
                                               4'h0;
  assign o_arb_sqi_wr_data_vld = w_in_addr || w_lsu_store;
  assign o_arb_fetch_vld       = w_in_data && (r_owner == OWN_FETCH);
  assign o_arb_lsu_rd_vld      = w_lsu_data && !r_wr;
  assign o_arb_lsu_done        = w_lsu_data && i_arb_ctr_last_cycle;
  assign o_arb_busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_arb_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_idli_sqi_arb_m
// Brief    : Directed self-checking bench for idli_sqi_arb_m.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_arb_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ctr = 2'd0;
  logic        last;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0000;
  logic        fetch_flush = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_wr = 1'b0;
  logic [15:0] lsu_addr = 16'h0000;
  logic [15:0] lsu_wr_data = 16'h0000;

  logic        redirect, sqi_rd, wr_data_vld, fetch_vld, lsu_rd_vld, lsu_done, busy;
  logic [3:0]  wr_data;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;

  assign last = (ctr == 2'd3);
  assign obs  = {redirect, sqi_rd, wr_data, wr_data_vld, fetch_vld, lsu_rd_vld, lsu_done, busy};

  always #5 clk = ~clk;
  always @(posedge clk) ctr <= ctr + 2'd1;

  idli_sqi_arb_m dut (
    .i_arb_gck             (clk),
    .i_arb_rst_n           (rst_n),
    .i_arb_ctr             (ctr),
    .i_arb_ctr_last_cycle  (last),
    .i_arb_fetch_req       (fetch_req),
    .i_arb_fetch_addr      (fetch_addr),
    .i_arb_fetch_flush     (fetch_flush),
    .i_arb_lsu_req         (lsu_req),
    .i_arb_lsu_wr          (lsu_wr),
    .i_arb_lsu_addr        (lsu_addr),
    .i_arb_lsu_wr_data     (lsu_wr_data),
    .o_arb_redirect        (redirect),
    .o_arb_sqi_rd          (sqi_rd),
    .o_arb_sqi_wr_data     (wr_data),
    .o_arb_sqi_wr_data_vld (wr_data_vld),
    .o_arb_fetch_vld       (fetch_vld),
    .o_arb_lsu_rd_vld      (lsu_rd_vld),
    .o_arb_lsu_done        (lsu_done),
    .o_arb_busy            (busy)
  );

  // Field packing for expected output vectors (order matches obs).
  function automatic logic [10:0] mk(input logic rd_dir_redirect, input logic rd,
                                     input logic [3:0] nib, input logic wdv,
                                     input logic fv, input logic lrv,
                                     input logic done, input logic bsy);
    return {rd_dir_redirect, rd, nib, wdv, fv, lrv, done, bsy};
  endfunction

  // Leaves the bench at the falling edge just before a word boundary.
  task automatic goto_last();
    int n = 0;
    @(negedge clk);
    while (ctr != 2'd3 && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  localparam logic [10:0] IDLE_V = 11'b0_1_0000_0_0_0_0_0;
  localparam logic [10:0] FDAT_V = 11'b0_1_0000_0_1_0_0_1;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, IDLE_V);
    end
    rst_n = 1'b1;
    goto_last();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_fetch_start();
    logic [15:0] a = 16'h1234;
    logic [10:0] e;
    fetch_req = 1'b1; fetch_addr = a;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, a[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fetch_addr_word c=%0d: got %b expected %b", c, obs, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== FDAT_V) begin
        errors++;
        $display("FAIL fetch_stream i=%0d: got %b expected %b", i, obs, FDAT_V);
      end
    end
  endtask

  task automatic test_lsu_load_preempt();
    logic [15:0] a = 16'hA5F0;
    logic [15:0] f = 16'h3000;
    logic [10:0] e;
    lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = a;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, a[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_addr_word c=%0d: got %b expected %b", c, obs, e);
      end
    end
    lsu_req = 1'b0; fetch_addr = f;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, (c == 3), 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_data_word c=%0d: got %b expected %b", c, obs, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, f[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL refetch_addr_word c=%0d: got %b expected %b", c, obs, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== FDAT_V) begin
        errors++;
        $display("FAIL refetch_data c=%0d: got %b expected %b", c, obs, FDAT_V);
      end
    end
    fetch_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL fetch_release_idle c=%0d: got %b expected %b", c, obs, IDLE_V);
      end
    end
  endtask

  task automatic test_lsu_store();
    logic [15:0] a = 16'h0010;
    logic [15:0] d = 16'hBEEF;
    logic [10:0] e;
    lsu_req = 1'b1; lsu_wr = 1'b1; lsu_addr = a; lsu_wr_data = d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, a[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL store_addr_word c=%0d: got %b expected %b", c, obs, e);
      end
    end
    lsu_req = 1'b0; lsu_wr = 1'b0; lsu_wr_data = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b0, 1'b0, d[c*4 +: 4], 1'b1, 1'b0, 1'b0, (c == 3), 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL store_data_word c=%0d: got %b expected %b", c, obs, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL store_then_idle c=%0d: got %b expected %b", c, obs, IDLE_V);
      end
    end
  endtask

  task automatic test_flush_vs_lsu();
    logic [15:0] a0 = 16'h0100;
    logic [15:0] fl = 16'h0200;
    logic [15:0] la = 16'h0F0F;
    logic [10:0] e;
    fetch_req = 1'b1; fetch_addr = a0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, a0[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fvl_fetch_addr c=%0d: got %b expected %b", c, obs, e);
      end
    end
    repeat (4) @(negedge clk);
    fetch_flush = 1'b1; fetch_addr = fl;
    lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = la;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, la[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fvl_lsu_first c=%0d: got %b expected %b", c, obs, e);
      end
    end
    fetch_flush = 1'b0; lsu_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, (c == 3), 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fvl_lsu_data c=%0d: got %b expected %b", c, obs, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, fl[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fvl_flush_addr c=%0d: got %b expected %b", c, obs, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== FDAT_V) begin
        errors++;
        $display("FAIL fvl_fetch_data c=%0d: got %b expected %b", c, obs, FDAT_V);
      end
    end
  endtask

  task automatic test_flush_alone();
    logic [15:0] fl = 16'h0040;
    logic [10:0] e;
    fetch_flush = 1'b1; fetch_addr = fl;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, fl[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL flush_addr c=%0d: got %b expected %b", c, obs, e);
      end
    end
    fetch_flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== FDAT_V) begin
        errors++;
        $display("FAIL flush_data c=%0d: got %b expected %b", c, obs, FDAT_V);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] la = 16'h1111;
    logic [15:0] fa = 16'h0040;
    logic [10:0] e;
    lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = la;
    repeat (4) @(negedge clk);
    lsu_req = 1'b0;
    @(negedge clk);
    e = mk(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_mid_pre_data: got %b expected %b", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL rst_mid_immediate: got %b expected %b", obs, IDLE_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL rst_mid_held: got %b expected %b", obs, IDLE_V);
    end
    @(negedge clk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL rst_mid_no_done: got %b expected %b", obs, IDLE_V);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = mk(1'b1, 1'b0, fa[c*4 +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_mid_refetch c=%0d: got %b expected %b", c, obs, e);
      end
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_start();
    test_lsu_load_preempt();
    test_lsu_store();
    test_flush_vs_lsu();
    test_flush_alone();
    test_reset_mid_word();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idli_sqi_arb_m.md
Name: idli_sqi_arb_m

Overview:
- Sequences the single SQI memory port between two requesters: instruction fetch and the load/store unit (LSU).
- Grants one owner per 16-bit word, i.e. per 4-cycle counter period.
- Drives the SQI controller's redirect, direction and write-nibble inputs.
- Gates decoder-valid and load-data-valid toward the core.
- Sits between the control counter and idli_sqi_ctrl_m inside idli_core_m.

Parameters:
- None. Word width is fixed at 16 bits, sent as 4 nibbles, LSB nibble first.

Ports:
- i_arb_gck  in  1  clock
- i_arb_rst_n  in  1  asynchronous active-low reset
- i_arb_ctr  in  2  nibble counter; value N selects bits [4N+3:4N]
- i_arb_ctr_last_cycle  in  1  high when i_arb_ctr==3; marks the word boundary
- i_arb_fetch_req  in  1  fetch wants the port
- i_arb_fetch_addr  in  16  fetch address (current PC)
- i_arb_fetch_flush  in  1  fetch restart at a new address (branch)
- i_arb_lsu_req  in  1  LSU wants one word
- i_arb_lsu_wr  in  1  1 = store, 0 = load
- i_arb_lsu_addr  in  16  LSU address
- i_arb_lsu_wr_data  in  16  store data
- o_arb_redirect  out  1  address phase active
- o_arb_sqi_rd  out  1  SQI data direction; 1 = read
- o_arb_sqi_wr_data  out  4  nibble to drive on SQI
- o_arb_sqi_wr_data_vld  out  1  o_arb_sqi_wr_data is meaningful
- o_arb_fetch_vld  out  1  current SQI read nibble belongs to fetch (decoder enc_vld)
- o_arb_lsu_rd_vld  out  1  current SQI read nibble is load data
- o_arb_lsu_done  out  1  single-cycle pulse; LSU word complete
- o_arb_busy  out  1  state != IDLE

Behaviour:
- State registers: state, owner (FETCH/LSU), addr_q[15:0], data_q[15:0], wr_q.
- All state registers change only on an edge where i_arb_ctr_last_cycle=1. Requests are sampled only at that edge.
- States: IDLE, ADDR, DATA. Each state lasts whole 4-cycle words.
- Latching: entering ADDR latches the owner's address into addr_q. For LSU it also latches i_arb_lsu_wr into wr_q and i_arb_lsu_wr_data into data_q.
- Transitions at each word boundary:
  - IDLE: lsu_req -> ADDR/LSU; else fetch_req -> ADDR/FETCH; else stay IDLE.
  - ADDR -> DATA, same owner.
  - DATA/LSU (always exactly one word): fetch_req -> ADDR/FETCH with a fresh i_arb_fetch_addr; else IDLE. The LSU is never granted back-to-back, which gives fetch a guaranteed slot.
  - DATA/FETCH, in priority order:
    - lsu_req -> ADDR/LSU
    - else fetch_flush -> ADDR/FETCH, re-latching i_arb_fetch_addr
    - else !fetch_req -> IDLE
    - else stay in DATA (sequential stream, no new address).
  - Simultaneous lsu_req and fetch_flush: LSU wins. The flush target is picked up when fetch is re-granted, because the address is read at grant time.
- Outputs are combinational from state, owner, registers and ctr:
  - o_arb_redirect = (state==ADDR).
  - o_arb_sqi_rd = 0 in ADDR; 0 in DATA/LSU with wr_q=1; 1 otherwise, including IDLE.
  - o_arb_sqi_wr_data:
    - ADDR: addr_q nibble[ctr]
    - DATA/LSU with wr_q: data_q nibble[ctr]
    - else 4'h0.
  - o_arb_sqi_wr_data_vld = ADDR | (DATA & LSU & wr_q).
  - o_arb_fetch_vld = DATA & owner==FETCH.
  - o_arb_lsu_rd_vld = DATA & owner==LSU & !wr_q.
  - o_arb_lsu_done = DATA & owner==LSU & i_arb_ctr_last_cycle. The LSU must drop lsu_req or change its request by the following boundary.
  - o_arb_busy = (state != IDLE).
- Latency: the first fetch data nibble appears 4 cycles after the boundary that follows a request, i.e. the ADDR word comes first.
- Reset (asynchronous, any cycle including mid-word):
  - state=IDLE, owner=FETCH, addr_q=data_q=0, wr_q=0.
  - Outputs: redirect=0, sqi_rd=1, wr_data=0, wr_data_vld=0, fetch_vld=0, lsu_rd_vld=0, lsu_done=0, busy=0.
  - No done pulse is issued for an aborted LSU word.
- Request inputs changing mid-word have no effect until the next boundary.

Test Plan:
- Fetch start: reset, then fetch_req=1, fetch_addr=16'h1234.
  -> ADDR word drives wr_data 4,3,2,1 with redirect=1 and rd=0.
  -> Next words show fetch_vld=1 and rd=1, continuously while req is held.
- LSU load preempts fetch: during fetch DATA, lsu_req=1, wr=0, addr=16'hA5F0.
  -> Next word is ADDR with nibbles 0,F,5,A.
  -> Then one DATA word with lsu_rd_vld=1 and lsu_done high only in its ctr=3 cycle.
  -> Then ADDR/FETCH with the current fetch_addr.
- LSU store: from IDLE, lsu_req=1, wr=1, addr=16'h0010, data=16'hBEEF.
  -> ADDR nibbles 0,1,0,0, then DATA nibbles F,E,E,B with rd=0 and wr_data_vld=1.
  -> Then IDLE (fetch_req=0), busy=0.
- Flush vs LSU: during fetch DATA, assert fetch_flush and lsu_req at the same boundary.
  -> LSU granted first.
  -> After lsu_done, fetch re-addresses with the flushed address 16'h0200.
- Flush alone: fetch streaming, flush=1, fetch_addr=16'h0040 at a boundary.
  -> One ADDR word with nibbles 0,4,0,0, then DATA with fetch_vld=1.
- Reset mid-word: assert rst_n=0 at ctr=1 during DATA/LSU.
  -> All outputs go to reset values immediately with no lsu_done.
  -> After release with fetch_req=1, the next boundary enters ADDR/FETCH.
